ysyx_22050854_idexe_reg: RTL and testbench
==========================================

YSYX_22050854_IDEXE_REG -- requirements
Module: ysyx_22050854_idexe_reg

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset, named as in the codebase:
- clk  in  1  single clock
- rst  in  1  synchronous, active-high reset
REQ-002 SHALL have these upstream (ID) ports:
- id_valid  in  1  ID holds a decoded instruction
- id_pc  in  64  instruction PC
- id_ALUctr  in  4  ALU opcode
- id_MULctr  in  4  mul/div opcode
- id_ALUext  in  3  ALU result-select
- id_src1, id_src2  in  64 each  operands
- id_rd  in  5  destination register
- id_wen  in  1  register-write enable
- exe_allowin  out  1  EXE accepts the ID instruction this cycle
REQ-003 SHALL have these EXE/ALU-side ports:
- EXEreg_valid  out  1  ALU operands valid
- ALUctr  out  4
- MULctr  out  4
- ALUext  out  3
- src1, src2  out  64 each
- alu_busy  in  1  multi-cycle mul/div in progress
REQ-004 SHALL have these downstream (MEM) and control ports:
- exe_pc  out  64
- exe_rd  out  5
- exe_wen  out  1
- exe_to_mem_valid  out  1  result ready for MEM
- mem_allowin  in  1  MEM accepts this cycle
- flush  in  1  squash younger instructions (branch redirect or trap)
- stall_cycles  out  32  saturating count of cycles stalled on alu_busy
- squash_cnt  out  32  saturating count of killed in-flight mul/div operations

Function
REQ-005 SHALL implement a 3-state FSM: EMPTY, FULL, DRAIN.
REQ-006 Signal definitions:
- ready_go = ~alu_busy
- EXEreg_valid = (state != EMPTY)
- exe_to_mem_valid = (state == FULL) & ready_go & ~flush
REQ-007 exe_allowin = ~flush & ((state == EMPTY) | ((state == FULL) & ready_go & mem_allowin)); SHALL be 0 in DRAIN.
REQ-008 Accept = id_valid & exe_allowin: load all id_* payload fields into the output registers on the next edge and enter or remain in FULL; latency ID to EXE is 1 cycle.
REQ-009 Without an accept, payload registers SHALL hold their value; src1/src2/MULctr SHALL stay stable for the whole time alu_busy is asserted.
REQ-010 In FULL with ~flush, ready_go & mem_allowin and no accept: go to EMPTY.
REQ-011 In FULL with ~flush, ready_go deasserted or mem_allowin deasserted: hold in FULL.
REQ-012 In FULL with flush & alu_busy: go to DRAIN; EXEreg_valid stays 1 so the ALU completes its non-cancellable mul/div; squash_cnt increments.
REQ-013 In FULL with flush & ~alu_busy: go to EMPTY.
REQ-014 In DRAIN: exe_to_mem_valid = 0; when alu_busy = 0, go to EMPTY and discard the result; flush while in DRAIN has no further effect.
REQ-015 In EMPTY: flush has no effect, and id_valid is not accepted in a flush cycle.
REQ-016 stall_cycles SHALL increment on each cycle where state == FULL & alu_busy; both counters saturate at 0xFFFF_FFFF and never wrap.
REQ-017 Simultaneous drain and accept in FULL (leave and load in one edge) SHALL keep the state FULL with the new payload and no bubble.

Reset
REQ-018 On rst at a clock edge:
- state = EMPTY
- all payload outputs = 0
- stall_cycles = 0, squash_cnt = 0
- exe_allowin = 1 in the first post-reset cycle
REQ-019 rst SHALL override flush and accept; rst asserted in DRAIN SHALL return to EMPTY immediately, and it is the integrator's responsibility to reset the ALU in the same cycle.

Structure
REQ-020 A shared package SHALL hold:
- the state encoding (EMPTY = 2'd0, FULL = 2'd1, DRAIN = 2'd2)
- width constants: XLEN = 64, CTRL_W = 4, EXT_W = 3, REG_W = 5
REQ-021 One sub-module, ysyx_22050854_satcnt (32-bit saturating counter with inc input, synchronous reset), SHALL be instantiated twice.
REQ-022 SHALL contain no combinational path from mem_allowin to EXEreg_valid.

Verification
REQ-023 The bench SHALL cover at least these directed scenarios:
- Reset, then id_valid = 1, id_src1 = 5, id_src2 = 7, alu_busy = 0, mem_allowin = 1 -> next cycle EXEreg_valid = 1, src1 = 5, src2 = 7, exe_to_mem_valid = 1.
- Mul accepted, alu_busy high for 33 cycles -> exe_allowin = 0 and src1/src2 stable for 33 cycles; stall_cycles = 33; exe_to_mem_valid = 1 on cycle 34.
- flush at cycle 10 of a busy div (busy lasts 65 cycles) -> DRAIN; EXEreg_valid = 1 until busy drops; exe_to_mem_valid = 0 throughout; squash_cnt = 1; then EMPTY.
- FULL, mem_allowin = 0 for 4 cycles with id_valid = 1 -> payload held, exe_allowin = 0; after release, back-to-back accept with no bubble cycle.
- flush with id_valid = 1 in EMPTY -> instruction not accepted; state stays EMPTY.
- stall_cycles preloaded to 0xFFFF_FFFE (force) and 3 further stall cycles -> reads 0xFFFF_FFFF.

Source files
------------

// File: rtl/ysyx_22050854_idexe_reg_pkg.sv
// Shared definitions for the ID/EXE pipeline register: state encoding,
// datapath widths and the payload bundle carried from ID into EXE.
package ysyx_22050854_idexe_reg_pkg;

  localparam int unsigned XLEN   = 64;
  localparam int unsigned CTRL_W = 4;
  localparam int unsigned EXT_W  = 3;
  localparam int unsigned REG_W  = 5;
  localparam int unsigned CNT_W  = 32;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_FULL  = 2'd1,
    S_DRAIN = 2'd2
  } idexe_state_e;

  typedef struct packed {
    logic [XLEN-1:0]   pc;
    logic [CTRL_W-1:0] alu_ctr;
    logic [CTRL_W-1:0] mul_ctr;
    logic [EXT_W-1:0]  alu_ext;
    logic [XLEN-1:0]   src1;
    logic [XLEN-1:0]   src2;
    logic [REG_W-1:0]  rd;
    logic              wen;
  } idexe_payload_t;

endpackage

// File: rtl/ysyx_22050854_satcnt.sv
// Free-running event counter that sticks at all-ones instead of wrapping.
module ysyx_22050854_satcnt
  import ysyx_22050854_idexe_reg_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (inc && (cnt != {CNT_W{1'b1}})) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/ysyx_22050854_idexe_reg.sv
// ID->EXE pipeline register with valid/allowin handshake; keeps a flushed
// multi-cycle mul/div alive in DRAIN until the ALU finishes and drops it.
module ysyx_22050854_idexe_reg
  import ysyx_22050854_idexe_reg_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  // ID side
  input  logic              id_valid,
  input  logic [XLEN-1:0]   id_pc,
  input  logic [CTRL_W-1:0] id_ALUctr,
  input  logic [CTRL_W-1:0] id_MULctr,
  input  logic [EXT_W-1:0]  id_ALUext,
  input  logic [XLEN-1:0]   id_src1,
  input  logic [XLEN-1:0]   id_src2,
  input  logic [REG_W-1:0]  id_rd,
  input  logic              id_wen,
  output logic              exe_allowin,
  // ALU side
  output logic              EXEreg_valid,
  output logic [CTRL_W-1:0] ALUctr,
  output logic [CTRL_W-1:0] MULctr,
  output logic [EXT_W-1:0]  ALUext,
  output logic [XLEN-1:0]   src1,
  output logic [XLEN-1:0]   src2,
  input  logic              alu_busy,
  // MEM side and control
  output logic [XLEN-1:0]   exe_pc,
  output logic [REG_W-1:0]  exe_rd,
  output logic              exe_wen,
  output logic              exe_to_mem_valid,
  input  logic              mem_allowin,
  input  logic              flush,
  output logic [CNT_W-1:0]  stall_cycles,
  output logic [CNT_W-1:0]  squash_cnt
);

  idexe_state_e   state_q;
  idexe_state_e   state_d;
  idexe_payload_t payload_q;
  idexe_payload_t id_payload;

  logic ready_go;
  logic accept;
  logic stall_inc;
  logic squash_inc;

  assign id_payload = '{
    pc:      id_pc,
    alu_ctr: id_ALUctr,
    mul_ctr: id_MULctr,
    alu_ext: id_ALUext,
    src1:    id_src1,
    src2:    id_src2,
    rd:      id_rd,
    wen:     id_wen
  };

  assign ready_go = ~alu_busy;

  // Handshake: allowin depends on mem_allowin, EXEreg_valid only on state.
  assign exe_allowin      = ~flush & ((state_q == S_EMPTY) |
                                      ((state_q == S_FULL) & ready_go & mem_allowin));
  assign accept           = id_valid & exe_allowin;
  assign EXEreg_valid     = (state_q != S_EMPTY);
  assign exe_to_mem_valid = (state_q == S_FULL) & ready_go & ~flush;

  assign stall_inc  = (state_q == S_FULL) & alu_busy;
  assign squash_inc = (state_q == S_FULL) & flush & alu_busy;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_EMPTY: begin
        if (accept) state_d = S_FULL;
      end
      S_FULL: begin
        if (flush) begin
          state_d = alu_busy ? S_DRAIN : S_EMPTY;
        end else if (ready_go && mem_allowin) begin
          state_d = accept ? S_FULL : S_EMPTY;
        end
      end
      S_DRAIN: begin
        if (!alu_busy) state_d = S_EMPTY;
      end
      default: state_d = S_EMPTY;
    endcase
  end

  // Payload only moves on accept, so operands stay frozen while the ALU is busy.
  always_ff @(posedge clk) begin
    if (rst) begin
      payload_q <= '0;
    end else if (accept) begin
      payload_q <= id_payload;
    end
  end

  assign exe_pc  = payload_q.pc;
  assign ALUctr  = payload_q.alu_ctr;
  assign MULctr  = payload_q.mul_ctr;
  assign ALUext  = payload_q.alu_ext;
  assign src1    = payload_q.src1;
  assign src2    = payload_q.src2;
  assign exe_rd  = payload_q.rd;
  assign exe_wen = payload_q.wen;

  ysyx_22050854_satcnt u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .inc (stall_inc),
    .cnt (stall_cycles)
  );

  ysyx_22050854_satcnt u_squash_cnt (
    .clk (clk),
    .rst (rst),
    .inc (squash_inc),
    .cnt (squash_cnt)
  );

endmodule

// File: tb/tb_ysyx_22050854_idexe_reg.sv
// Directed bench for the ID/EXE register, checked every cycle against an
// occupancy model of the pipeline slot plus literal spot checks.
module tb_ysyx_22050854_idexe_reg;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid;
  logic [63:0] id_pc;
  logic [3:0]  id_ALUctr;
  logic [3:0]  id_MULctr;
  logic [2:0]  id_ALUext;
  logic [63:0] id_src1;
  logic [63:0] id_src2;
  logic [4:0]  id_rd;
  logic        id_wen;
  logic        exe_allowin;
  logic        EXEreg_valid;
  logic [3:0]  ALUctr;
  logic [3:0]  MULctr;
  logic [2:0]  ALUext;
  logic [63:0] src1;
  logic [63:0] src2;
  logic        alu_busy;
  logic [63:0] exe_pc;
  logic [4:0]  exe_rd;
  logic        exe_wen;
  logic        exe_to_mem_valid;
  logic        mem_allowin;
  logic        flush;
  logic [31:0] stall_cycles;
  logic [31:0] squash_cnt;

  int n_cmp = 0;
  int n_err = 0;

  ysyx_22050854_idexe_reg dut (
    .clk              (clk),
    .rst              (rst),
    .id_valid         (id_valid),
    .id_pc            (id_pc),
    .id_ALUctr        (id_ALUctr),
    .id_MULctr        (id_MULctr),
    .id_ALUext        (id_ALUext),
    .id_src1          (id_src1),
    .id_src2          (id_src2),
    .id_rd            (id_rd),
    .id_wen           (id_wen),
    .exe_allowin      (exe_allowin),
    .EXEreg_valid     (EXEreg_valid),
    .ALUctr           (ALUctr),
    .MULctr           (MULctr),
    .ALUext           (ALUext),
    .src1             (src1),
    .src2             (src2),
    .alu_busy         (alu_busy),
    .exe_pc           (exe_pc),
    .exe_rd           (exe_rd),
    .exe_wen          (exe_wen),
    .exe_to_mem_valid (exe_to_mem_valid),
    .mem_allowin      (mem_allowin),
    .flush            (flush),
    .stall_cycles     (stall_cycles),
    .squash_cnt       (squash_cnt)
  );

  always #10 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  // Model: one slot holding at most one instruction; a doomed instruction was
  // flushed mid-operation and only waits for the ALU before vanishing.
  bit          chk_en = 0;
  bit          m_occ, m_doomed;
  logic [63:0] m_pc, m_src1, m_src2;
  logic [3:0]  m_alu, m_mul;
  logic [2:0]  m_ext;
  logic [4:0]  m_rd;
  logic        m_wen;
  logic [31:0] m_stall, m_squash;

  function automatic bit exp_allowin();
    if (flush) return 0;
    if (!m_occ) return 1;
    return !m_doomed && !alu_busy && mem_allowin;
  endfunction

  function automatic bit exp_to_mem();
    return m_occ && !m_doomed && !alu_busy && !flush;
  endfunction

  always @(posedge clk) begin
    bit take, leave;
    if (rst) begin
      chk_en = 1;
      m_occ = 0; m_doomed = 0;
      m_pc = 0; m_src1 = 0; m_src2 = 0;
      m_alu = 0; m_mul = 0; m_ext = 0; m_rd = 0; m_wen = 0;
      m_stall = 0; m_squash = 0;
    end else begin
      take  = id_valid && exp_allowin();
      leave = 0;
      if (m_occ && !m_doomed && alu_busy && m_stall != 32'hFFFF_FFFF) m_stall++;
      if (m_occ) begin
        if (m_doomed) begin
          leave = !alu_busy;
        end else if (flush) begin
          if (alu_busy) begin
            m_doomed = 1;
            if (m_squash != 32'hFFFF_FFFF) m_squash++;
          end else begin
            leave = 1;
          end
        end else begin
          leave = !alu_busy && mem_allowin;
        end
      end
      if (take) begin
        m_occ = 1; m_doomed = 0;
        m_pc = id_pc; m_src1 = id_src1; m_src2 = id_src2;
        m_alu = id_ALUctr; m_mul = id_MULctr; m_ext = id_ALUext;
        m_rd = id_rd; m_wen = id_wen;
      end else if (leave) begin
        m_occ = 0; m_doomed = 0;
      end
    end
  end

  // Compare process: inputs change on negedge, outputs sampled 2 units later.
  always @(negedge clk) begin
    #2;
    if (chk_en) begin
      chk("EXEreg_valid", 64'(EXEreg_valid), 64'(m_occ));
      chk("exe_allowin", 64'(exe_allowin), 64'(exp_allowin()));
      chk("exe_to_mem_valid", 64'(exe_to_mem_valid), 64'(exp_to_mem()));
      chk("src1", src1, m_src1);
      chk("src2", src2, m_src2);
      chk("exe_pc", exe_pc, m_pc);
      chk("ctrl", 64'({ALUctr, MULctr, ALUext}), 64'({m_alu, m_mul, m_ext}));
      chk("rd_wen", 64'({exe_rd, exe_wen}), 64'({m_rd, m_wen}));
      chk("stall_cycles", 64'(stall_cycles), 64'(m_stall));
      chk("squash_cnt", 64'(squash_cnt), 64'(m_squash));
    end
  end

  task automatic set_id(input logic v, input logic [63:0] pc, input logic [63:0] s1,
                        input logic [63:0] s2, input logic [3:0] mul);
    id_valid  = v;
    id_pc     = pc;
    id_src1   = s1;
    id_src2   = s2;
    id_MULctr = mul;
    id_ALUctr = pc[5:2];
    id_ALUext = pc[4:2];
    id_rd     = pc[6:2];
    id_wen    = pc[2];
  endtask

  initial begin
    rst = 1; flush = 0; alu_busy = 0; mem_allowin = 1;
    set_id(0, 64'h0, 64'h0, 64'h0, 4'h0);
    repeat (2) @(negedge clk);

    // Reset state, then a single ALU op
    rst = 0;
    set_id(1, 64'h8000_0004, 64'd5, 64'd7, 4'h0);
    #3;
    chk("lit_reset_allowin", 64'(exe_allowin), 64'd1);
    chk("lit_reset_valid", 64'(EXEreg_valid), 64'd0);
    chk("lit_reset_src1", src1, 64'd0);
    chk("lit_reset_stall", 64'(stall_cycles), 64'd0);
    @(negedge clk);
    set_id(0, 64'h0, 64'h0, 64'h0, 4'h0);
    #3;
    chk("lit_s1_valid", 64'(EXEreg_valid), 64'd1);
    chk("lit_s1_src1", src1, 64'd5);
    chk("lit_s1_src2", src2, 64'd7);
    chk("lit_s1_to_mem", 64'(exe_to_mem_valid), 64'd1);
    @(negedge clk);

    // Mul busy for 33 cycles
    set_id(1, 64'h8000_0010, 64'd3, 64'd9, 4'h1);
    @(negedge clk);
    set_id(0, 64'h0, 64'h0, 64'h0, 4'h0);
    alu_busy = 1;
    for (int i = 0; i < 33; i++) begin
      #3;
      chk("lit_mul_allowin", 64'(exe_allowin), 64'd0);
      chk("lit_mul_src1", src1, 64'd3);
      chk("lit_mul_src2", src2, 64'd9);
      @(negedge clk);
    end
    alu_busy = 0;
    #3;
    chk("lit_mul_stall", 64'(stall_cycles), 64'd33);
    chk("lit_mul_to_mem", 64'(exe_to_mem_valid), 64'd1);
    @(negedge clk);

    // Div busy 65 cycles, flushed at busy cycle 10, flush again in DRAIN
    set_id(1, 64'h8000_0020, 64'd11, 64'd2, 4'h5);
    @(negedge clk);
    set_id(0, 64'h0, 64'h0, 64'h0, 4'h0);
    alu_busy = 1;
    for (int i = 0; i < 65; i++) begin
      flush = (i == 9) || (i == 20);
      #3;
      chk("lit_div_valid", 64'(EXEreg_valid), 64'd1);
      chk("lit_div_to_mem", 64'(exe_to_mem_valid), 64'd0);
      @(negedge clk);
    end
    flush = 0; alu_busy = 0;
    #3;
    chk("lit_drain_last_valid", 64'(EXEreg_valid), 64'd1);
    chk("lit_drain_last_to_mem", 64'(exe_to_mem_valid), 64'd0);
    @(negedge clk);
    #3;
    chk("lit_drain_empty", 64'(EXEreg_valid), 64'd0);
    chk("lit_squash", 64'(squash_cnt), 64'd1);
    chk("lit_stall_after_div", 64'(stall_cycles), 64'd43);

    // MEM back-pressure for 4 cycles with ID waiting, then back-to-back accepts
    set_id(1, 64'h8000_0100, 64'h100, 64'h1, 4'h0);
    @(negedge clk);
    mem_allowin = 0;
    set_id(1, 64'h8000_0200, 64'h200, 64'h2, 4'h0);
    for (int i = 0; i < 4; i++) begin
      #3;
      chk("lit_bp_allowin", 64'(exe_allowin), 64'd0);
      chk("lit_bp_src1", src1, 64'h100);
      @(negedge clk);
    end
    mem_allowin = 1;
    #3;
    chk("lit_bp_release_allowin", 64'(exe_allowin), 64'd1);
    @(negedge clk);
    set_id(1, 64'h8000_0300, 64'h300, 64'h3, 4'h0);
    #3;
    chk("lit_b2b_valid", 64'(EXEreg_valid), 64'd1);
    chk("lit_b2b_src1", src1, 64'h200);
    @(negedge clk);
    set_id(0, 64'h0, 64'h0, 64'h0, 4'h0);
    #3;
    chk("lit_b2b2_src1", src1, 64'h300);
    chk("lit_b2b2_valid", 64'(EXEreg_valid), 64'd1);
    @(negedge clk);

    // Flush in EMPTY blocks a pending ID instruction
    flush = 1;
    set_id(1, 64'h8000_0400, 64'h400, 64'h4, 4'h0);
    #3;
    chk("lit_eflush_allowin", 64'(exe_allowin), 64'd0);
    @(negedge clk);
    flush = 0;
    set_id(0, 64'h0, 64'h0, 64'h0, 4'h0);
    #3;
    chk("lit_eflush_valid", 64'(EXEreg_valid), 64'd0);
    chk("lit_eflush_src1", src1, 64'h300);

    // Reset while draining
    set_id(1, 64'h8000_0500, 64'h500, 64'h5, 4'h2);
    @(negedge clk);
    set_id(0, 64'h0, 64'h0, 64'h0, 4'h0);
    alu_busy = 1;
    @(negedge clk);
    flush = 1;
    @(negedge clk);
    flush = 0; rst = 1;
    #3;
    chk("lit_drain_before_rst", 64'(EXEreg_valid), 64'd1);
    @(negedge clk);
    rst = 0; alu_busy = 0;
    #3;
    chk("lit_rst_drain_valid", 64'(EXEreg_valid), 64'd0);
    chk("lit_rst_drain_squash", 64'(squash_cnt), 64'd0);
    chk("lit_rst_drain_src1", src1, 64'd0);

    // Stall counter saturation from a preloaded value
    #1;
    force dut.u_stall_cnt.cnt = 32'hFFFF_FFFE;
    m_stall = 32'hFFFF_FFFE;
    #1;
    release dut.u_stall_cnt.cnt;
    @(negedge clk);
    set_id(1, 64'h8000_0600, 64'h600, 64'h6, 4'h1);
    @(negedge clk);
    set_id(0, 64'h0, 64'h0, 64'h0, 4'h0);
    alu_busy = 1;
    repeat (3) @(negedge clk);
    alu_busy = 0;
    #3;
    chk("lit_stall_sat", 64'(stall_cycles), 64'hFFFF_FFFF);
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
